// File: rtl/llc_set_hazard_fifo.sv
// llc_set_hazard_fifo: set-tagged stage buffer between LLC pipeline stages.
// Holds DEPTH packets with their set index, answers NUM_QUERY combinational
// "set in flight?" queries, and optionally keeps the last popped set live
// as a hazard until the downstream stage signals release.
module llc_set_hazard_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 9,
    parameter int DEPTH      = 4,
    parameter int NUM_QUERY  = 2,
    parameter int HOLD_EN    = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  logic                          i_push_valid,
    output logic                          o_push_ready,
    input  logic [DATA_WIDTH-1:0]         i_push_data,
    input  logic [SET_BITS-1:0]           i_push_set,
    output logic                          o_pop_valid,
    input  logic                          i_pop_ready,
    output logic [DATA_WIDTH-1:0]         o_pop_data,
    output logic [SET_BITS-1:0]           o_pop_set,
    input  logic                          i_release,
    output logic                          o_hold_valid,
    input  logic [NUM_QUERY*SET_BITS-1:0] i_query_set,
    output logic [NUM_QUERY-1:0]          o_query_hit,
    output logic [$clog2(DEPTH+1)-1:0]    o_usage,
    output logic                          o_full,
    output logic                          o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [SET_BITS-1:0]   r_set  [DEPTH];
    // one occupancy flag per slot keeps the hazard compare a flat AND-OR
    logic [DEPTH-1:0]      r_occ;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic [SET_BITS-1:0]   r_hold_set;
    logic                  r_hold_valid;

    logic w_push_fire;
    logic w_pop_fire;
    logic w_hold_ok;

    assign o_full       = (r_count == CW'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_usage      = r_count;
    assign o_hold_valid = r_hold_valid;
    assign o_push_ready = !o_full && !i_flush;
    // with a hold register, a new pop needs the previous set released first
    assign w_hold_ok    = (HOLD_EN == 0) || !r_hold_valid || i_release;
    assign o_pop_valid  = !o_empty && !i_flush && w_hold_ok;
    assign w_push_fire  = i_push_valid && o_push_ready;
    assign w_pop_fire   = o_pop_valid && i_pop_ready;
    assign o_pop_data   = r_data[r_rd_ptr];
    assign o_pop_set    = r_set[r_rd_ptr];

    // payload storage; not reset, stale contents are masked by r_occ
    always_ff @(posedge i_clk) begin
        if (w_push_fire) begin
            r_data[r_wr_ptr] <= i_push_data;
            r_set[r_wr_ptr]  <= i_push_set;
        end
    end

    // pointers, occupancy and count; flush and reset both empty the buffer
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_occ    <= '0;
        end else begin
            if (w_pop_fire) begin
                r_rd_ptr        <= r_rd_ptr + PW'(1);
                r_occ[r_rd_ptr] <= 1'b0;
            end
            if (w_push_fire) begin
                r_wr_ptr        <= r_wr_ptr + PW'(1);
                r_occ[r_wr_ptr] <= 1'b1;
            end
            case ({w_push_fire, w_pop_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // hold register: captures each popped set, cleared by a bare release
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush || (HOLD_EN == 0)) begin
            r_hold_valid <= 1'b0;
            r_hold_set   <= '0;
        end else if (w_pop_fire) begin
            r_hold_valid <= 1'b1;
            r_hold_set   <= o_pop_set;
        end else if (i_release) begin
            r_hold_valid <= 1'b0;
        end
    end

    // per-port hazard compare against every occupied slot plus the hold set
    for (genvar q = 0; q < NUM_QUERY; q++) begin : g_query
        logic [SET_BITS-1:0] w_qs;
        assign w_qs = i_query_set[q*SET_BITS +: SET_BITS];
        always_comb begin
            o_query_hit[q] = r_hold_valid && (r_hold_set == w_qs);
            for (int j = 0; j < DEPTH; j++) begin
                if (r_occ[j] && (r_set[j] == w_qs)) o_query_hit[q] = 1'b1;
            end
        end
    end

endmodule

// File: doc/llc_set_hazard_fifo.md
# llc_set_hazard_fifo

Parametrised, set-aware stage buffer for the pipelined LLC. It replaces the fixed depth-1 inter-stage FIFOs between decode, memory read, lookup, process and update. It holds DEPTH in-flight packets, each tagged with its LLC set index. It answers NUM_QUERY combinational "set in flight?" queries so the input decoder can stall same-set requests. An optional hold register keeps the most recently popped set visible as a hazard until the downstream stage pulses `release`.

## Interface
Parameters:
- DATA_WIDTH, 32, payload bits per entry (packed stage packet)
- SET_BITS, 9, set-index width (matches LLC_SET_BITS)
- DEPTH, 4, entry count; power of two, 2..16
- NUM_QUERY, 2, number of independent hazard query ports
- HOLD_EN, 1, 1 = popped set held until `release`; 0 = no hold register

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  drop all entries and the hold register
- push_valid  in  1  producer has an entry
- push_ready  out  1  entry can be accepted
- push_data  in  DATA_WIDTH  payload
- push_set  in  SET_BITS  set index of the entry
- pop_valid  out  1  head entry available
- pop_ready  in  1  consumer takes the head
- pop_data  out  DATA_WIDTH  head payload
- pop_set  out  SET_BITS  head set index
- release  in  1  downstream done with the held set
- hold_valid  out  1  hold register occupied
- query_set  in  NUM_QUERY*SET_BITS  query i in bits [i*SET_BITS +: SET_BITS]
- query_hit  out  NUM_QUERY  per-query match
- usage  out  $clog2(DEPTH+1)  occupied entries
- full  out  1  usage == DEPTH
- empty  out  1  usage == 0

## Operation
- **Storage:** register array indexed by rd_ptr and wr_ptr, each $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0. A count register of $clog2(DEPTH+1) bits tracks occupancy.
- **Handshakes:**
  - push_ready = !full && !flush.
  - push_ready does not depend on pop_ready, so there is no push-through when full.
  - push fire = push_valid && push_ready: writes data and set at wr_ptr, increments wr_ptr.
  - HOLD_EN=1: pop_valid = !empty && !flush && (!hold_valid || release).
  - HOLD_EN=0: pop_valid = !empty && !flush.
  - pop fire = pop_valid && pop_ready: increments rd_ptr.
  - pop_data and pop_set always show entry[rd_ptr]. Their value is don't-care when empty.
- **Count:** push-only +1; pop-only -1; both or neither unchanged.
- **Hold (HOLD_EN=1):**
  - Pop fire loads hold_set <= pop_set and sets hold_valid.
  - release without pop fire clears hold_valid.
  - release with pop fire in the same cycle reloads hold_set; hold_valid stays 1.
  - release while hold_valid=0 is ignored.
- **Hazard query:** query_hit[i] is set when any occupied entry's set equals query_set[i], or when hold_valid && hold_set == query_set[i].
  - Fully combinational from registered state.
  - A push in the current cycle is not visible until the next cycle.
  - An entry popping this cycle still hits in this cycle.
- **Flush:** highest priority over push, pop and release. Next cycle: count=0, rd_ptr=wr_ptr=0, hold_valid=0. Array contents are left stale.
- **Reset values** (cycle after rst sampled high): push_ready=1, pop_valid=0, hold_valid=0, query_hit=0, usage=0, full=0, empty=1, pointers 0. Reset mid-operation discards all entries exactly like flush.

## Timing
- Push-to-pop latency: 1 cycle. An entry pushed at edge N gives pop_valid=1 after edge N, with no same-cycle bypass.
- Throughput: 1 push and 1 pop per cycle sustained while 0 < usage < DEPTH.
- full, empty and usage are derived from registered count only, with no combinational path from push_valid or pop_ready.
- query_hit timing is combinational from query_set only: one SET_BITS compare per entry plus hold, OR-reduced. This must meet single-cycle timing at DEPTH=16.
- With HOLD_EN=1, a pop-release turnaround allows back-to-back pops only when release is asserted in the cycle of the second pop.

## Test plan
- **Fill/drain, DEPTH=4:** push sets 0x01,0x02,0x03,0x04 with data 0xA0..0xA3.
  - full=1 and push_ready=0 after the 4th push; usage=4.
  - Pop 4 times with release every cycle: data 0xA0..0xA3 in order; empty=1 at end.
- **Wrap-around:** sustain simultaneous push and pop for 10 cycles at usage=2. Usage stays 2 and data order is preserved across the pointer wrap.
- **Hazard query:** entries with sets 0x10 and 0x20 are occupied, hold_set=0x30 and hold_valid=1.
  - query_set=(0x20, 0x30) gives query_hit=2'b11.
  - query_set=(0x40, 0x10) gives 2'b10.
  - A push of 0x40 this cycle leaves 0x40 not hitting until the next cycle.
- **Hold gating:** usage=1 and hold_valid=1.
  - pop_valid=0 until release is asserted.
  - In the cycle release=1, pop_valid=1 and the pop fires. hold_set becomes the popped set and hold_valid stays 1.
  - release alone with usage=0 clears hold_valid.
- **Flush/reset priority:** with usage=3 and hold_valid=1, assert flush together with push_valid and pop_ready.
  - push_ready=0 and pop_valid=0 in the flush cycle.
  - Next cycle: usage=0, empty=1, hold_valid=0, query_hit=0.
  - Repeat the same sequence with rst=1 in place of flush: identical result.
- **HOLD_EN=0, DEPTH=16:** pop fires whenever the FIFO is non-empty regardless of release. query_hit covers only occupied entries. full is asserted at usage=16.
